// File: rtl/codec_map_dec_pkg.sv
// Shared types and helpers for the MAP decoder input buffer sequencer.
package codec_map_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_DECODE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 3;
    localparam int ITER_W_MAX  = 16;

    // An iteration count of zero still runs the frame once.
    function automatic logic [ITER_W_MAX-1:0] iter_clamp(input logic [ITER_W_MAX-1:0] iter);
        return (iter == '0) ? ITER_W_MAX'(1) : iter;
    endfunction

endpackage

// File: rtl/codec_map_dec_valid_pipe.sv
// Enable-gated shift register carrying {val, first, last, iter} alongside the
// RAM read pipeline so the tags emerge aligned with the read data.
module codec_map_dec_valid_pipe
    import codec_map_dec_pkg::*;
#(
    parameter int pLAT    = 1,
    parameter int pITER_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               val_i,
    input  logic               first_i,
    input  logic               last_i,
    input  logic [pITER_W-1:0] iter_i,
    output logic               val_o,
    output logic               first_o,
    output logic               last_o,
    output logic [pITER_W-1:0] iter_o
);

    localparam int W = pITER_W + 3;

    if (pLAT < RAM_LAT_MIN || pLAT > RAM_LAT_MAX) begin : g_bad_lat
        $error("codec_map_dec_valid_pipe: pLAT out of range");
    end

    logic [W-1:0] stage_q [pLAT];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < pLAT; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= {val_i, first_i, last_i, iter_i};
            for (int i = 1; i < pLAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign {val_o, first_o, last_o, iter_o} = stage_q[pLAT-1];

endmodule

// File: rtl/codec_map_dec_input_ram_ctrl.sv
// Fill/decode sequencer for the two-bank MAP decoder input RAM.
// Optional odd-length flag: CODEC_MAP_DEC_INPUT_RAM_CTRL_PARITY_CHECK_EN.
module codec_map_dec_input_ram_ctrl
    import codec_map_dec_pkg::*;
#(
    parameter int pADDR_W  = 8,
    parameter int pRAM_LAT = 1,
    parameter int pITER_W  = 4
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               isop,
    input  logic               ival,
    input  logic               ieop,
    output logic               ordy,
    input  logic [pITER_W-1:0] iiter,
    input  logic               idec_rdy,
    output logic               owrite,
    output logic [pADDR_W-1:0] owaddr,
    output logic               orclkena,
    output logic               oread,
    output logic [pADDR_W-1:0] oraddr0,
    output logic [pADDR_W-1:0] oraddr1,
    output logic               ordval,
    output logic               ofirst,
    output logic               olast,
    output logic [pITER_W-1:0] oiter,
    output logic               obusy,
    output logic               odone,
    output logic               oerr
);

    localparam int CW = pADDR_W + 1;
    localparam logic [pADDR_W-1:0] ADDR_MAX = '1;

    state_t             state_q;
    logic [pADDR_W-1:0] waddr_q, owaddr_q, raddr0_q, raddr1_q;
    logic [CW-1:0]      n_q, k_q;
    logic [pITER_W-1:0] iter_q, niter_q, riter_q;
    logic [1:0]         flush_q;
    logic               ordy_q, owrite_q, oread_q, first_q, last_q, odone_q;

    logic               accept_d, rd_en_d, wr_take_d, frame_end_d, pair_last_d, iter_last_d;
    logic [pADDR_W-1:0] wa_d, k_rev_d;
    logic [CW-1:0]      n_d;
    logic [pITER_W-1:0] niter_d;

    assign accept_d    = iclkena & ival & ordy_q;
    assign rd_en_d     = iclkena & idec_rdy;
    assign wr_take_d   = accept_d & (isop | (state_q == ST_FILL));
    assign wa_d        = isop ? '0 : waddr_q;
    assign frame_end_d = wr_take_d & (ieop | (wa_d == ADDR_MAX));
    assign n_d         = {1'b0, wa_d} + CW'(1);
    assign k_rev_d     = pADDR_W'(n_q - CW'(1) - k_q);
    assign pair_last_d = (k_q == n_q - CW'(1));
    assign iter_last_d = (iter_q == niter_q - pITER_W'(1));
    assign niter_d     = pITER_W'(iter_clamp(ITER_W_MAX'(iiter)));

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q  <= ST_IDLE;
            waddr_q  <= '0;
            owaddr_q <= '0;
            raddr0_q <= '0;
            raddr1_q <= '0;
            n_q      <= '0;
            k_q      <= '0;
            iter_q   <= '0;
            niter_q  <= '0;
            riter_q  <= '0;
            flush_q  <= '0;
            ordy_q   <= 1'b0;
            owrite_q <= 1'b0;
            oread_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            odone_q  <= 1'b0;
        end else if (iclkena) begin
            owrite_q <= 1'b0;
            odone_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    ordy_q <= 1'b1;
                    if (wr_take_d) begin
                        owrite_q <= 1'b1;
                        owaddr_q <= wa_d;
                        waddr_q  <= wa_d + pADDR_W'(1);
                        state_q  <= ST_FILL;
                        if (isop) niter_q <= niter_d;
                        if (frame_end_d) begin
                            n_q     <= n_d;
                            k_q     <= '0;
                            iter_q  <= '0;
                            ordy_q  <= 1'b0;
                            state_q <= ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (rd_en_d) begin
                        oread_q  <= 1'b1;
                        raddr0_q <= pADDR_W'(k_q);
                        raddr1_q <= k_rev_d;
                        first_q  <= (k_q == '0);
                        last_q   <= pair_last_d;
                        riter_q  <= iter_q;
                        if (pair_last_d) begin
                            k_q <= '0;
                            if (iter_last_d) begin
                                iter_q  <= '0;
                                flush_q <= '0;
                                state_q <= ST_FLUSH;
                            end else begin
                                iter_q <= iter_q + pITER_W'(1);
                            end
                        end else begin
                            k_q <= k_q + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // Count enabled ticks until the last pair leaves the RAM pipeline.
                    if (rd_en_d) begin
                        oread_q <= 1'b0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        riter_q <= '0;
                        if (flush_q == 2'(pRAM_LAT)) begin
                            odone_q <= 1'b1;
                            ordy_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            flush_q <= flush_q + 2'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CODEC_MAP_DEC_INPUT_RAM_CTRL_PARITY_CHECK_EN
    logic oerr_q;

    // Odd N means wa_d (= N-1) is even at frame close.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            oerr_q <= 1'b0;
        end else if (iclkena) begin
            if (frame_end_d) begin
                oerr_q <= ~wa_d[0];
            end else if (wr_take_d && isop && state_q == ST_IDLE) begin
                oerr_q <= 1'b0;
            end
        end
    end

    assign oerr = oerr_q;
`else
    assign oerr = 1'b0;
`endif

    codec_map_dec_valid_pipe #(
        .pLAT    (pRAM_LAT),
        .pITER_W (pITER_W)
    ) u_valid_pipe (
        .clk_i   (iclk),
        .rst_n_i (ireset),
        .en_i    (orclkena),
        .val_i   (oread_q),
        .first_i (first_q),
        .last_i  (last_q),
        .iter_i  (riter_q),
        .val_o   (ordval),
        .first_o (ofirst),
        .last_o  (olast),
        .iter_o  (oiter)
    );

    assign orclkena = iclkena & idec_rdy;
    assign ordy     = ordy_q;
    assign owrite   = owrite_q;
    assign owaddr   = owaddr_q;
    assign oread    = oread_q;
    assign oraddr0  = raddr0_q;
    assign oraddr1  = raddr1_q;
    assign obusy    = (state_q == ST_DECODE);
    assign odone    = odone_q;

endmodule

// File: tb/tb_codec_map_dec_input_ram_ctrl.sv
// Scoreboard bench for codec_map_dec_input_ram_ctrl: expected writes, read pairs
// and output tags are queued at stimulus time and popped as the DUT produces them.
module tb_codec_map_dec_input_ram_ctrl;

    localparam int AW   = 8;
    localparam int LAT  = 3;
    localparam int IW   = 4;
    localparam int NMAX = 1 << AW;
`ifdef CODEC_MAP_DEC_INPUT_RAM_CTRL_PARITY_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic          iclk = 1'b0, ireset = 1'b0, iclkena = 1'b1;
    logic          isop = 1'b0, ival = 1'b0, ieop = 1'b0, idec_rdy = 1'b1;
    logic [IW-1:0] iiter = '0;
    logic          ordy, owrite, orclkena, oread, ordval, ofirst, olast, obusy, odone, oerr;
    logic [AW-1:0] owaddr, oraddr0, oraddr1;
    logic [IW-1:0] oiter;

    always #5 iclk = ~iclk;

    codec_map_dec_input_ram_ctrl #(.pADDR_W(AW), .pRAM_LAT(LAT), .pITER_W(IW)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
        .ieop(ieop), .ordy(ordy), .iiter(iiter), .idec_rdy(idec_rdy), .owrite(owrite),
        .owaddr(owaddr), .orclkena(orclkena), .oread(oread), .oraddr0(oraddr0),
        .oraddr1(oraddr1), .ordval(ordval), .ofirst(ofirst), .olast(olast), .oiter(oiter),
        .obusy(obusy), .odone(odone), .oerr(oerr)
    );

    typedef struct {
        int a0;
        int a1;
        bit first;
        bit last;
        int iter;
        bit frame_start;
        bit final_pair;
    } rd_t;

    int  chk_cnt = 0, pass_cnt = 0;
    int  exp_w[$];
    rd_t exp_r[$];
    rd_t exp_v[$];
    int  rd_tick[$];
    int  en_cnt = 0, last_rd_tick = 0, final_val_tick = -100, done_cnt = 0;
    int  mon_w, mon_t;
    rd_t mon_r;

    always @(posedge iclk) if (ireset && iclkena && idec_rdy) en_cnt++;

    always @(negedge iclk) begin
        if (ireset) begin
            if (owrite && iclkena) begin
                chk_cnt++;
                if (exp_w.size() == 0) $display("FAIL write_unexpected owaddr=%0d", owaddr);
                else begin
                    mon_w = exp_w.pop_front();
                    if (int'(owaddr) !== mon_w) $display("FAIL write_addr got=%0d exp=%0d", owaddr, mon_w);
                    else pass_cnt++;
                end
            end
            if (oread && orclkena) begin
                chk_cnt++;
                if (exp_r.size() == 0) $display("FAIL read_unexpected a0=%0d a1=%0d", oraddr0, oraddr1);
                else begin
                    mon_r = exp_r.pop_front();
                    if (int'(oraddr0) !== mon_r.a0 || int'(oraddr1) !== mon_r.a1)
                        $display("FAIL read_pair got=(%0d,%0d) exp=(%0d,%0d)", oraddr0, oraddr1, mon_r.a0, mon_r.a1);
                    else pass_cnt++;
                    if (!mon_r.frame_start) begin
                        chk_cnt++;
                        if (en_cnt !== last_rd_tick + 1)
                            $display("FAIL read_bubble got_tick=%0d exp_tick=%0d", en_cnt, last_rd_tick + 1);
                        else pass_cnt++;
                    end
                    last_rd_tick = en_cnt;
                    rd_tick.push_back(en_cnt);
                end
            end
            if (ordval && orclkena) begin
                chk_cnt++;
                if (exp_v.size() == 0 || rd_tick.size() == 0) $display("FAIL rdval_unexpected iter=%0d", oiter);
                else begin
                    mon_r = exp_v.pop_front();
                    mon_t = rd_tick.pop_front();
                    if (ofirst !== mon_r.first || olast !== mon_r.last || int'(oiter) !== mon_r.iter)
                        $display("FAIL rdval_tags got=f%0b l%0b i%0d exp=f%0b l%0b i%0d",
                                 ofirst, olast, oiter, mon_r.first, mon_r.last, mon_r.iter);
                    else pass_cnt++;
                    chk_cnt++;
                    if (en_cnt - mon_t !== LAT) $display("FAIL rdval_latency got=%0d exp=%0d", en_cnt - mon_t, LAT);
                    else pass_cnt++;
                    if (mon_r.final_pair) final_val_tick = en_cnt;
                end
            end
            if (odone) begin
                done_cnt++;
                chk_cnt++;
                if (en_cnt !== final_val_tick + 1)
                    $display("FAIL done_timing got_tick=%0d exp_tick=%0d", en_cnt, final_val_tick + 1);
                else pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic push_reads(input int n, input int it);
        rd_t r;
        int  ni;
        ni = (it == 0) ? 1 : it;
        for (int i = 0; i < ni; i++) begin
            for (int k = 0; k < n; k++) begin
                r.a0 = k; r.a1 = n - 1 - k; r.first = (k == 0); r.last = (k == n - 1);
                r.iter = i; r.frame_start = (i == 0 && k == 0); r.final_pair = (i == ni - 1 && k == n - 1);
                exp_r.push_back(r);
                exp_v.push_back(r);
            end
        end
    endtask

    task automatic send_frame(input int n, input int it);
        push_reads(n, it);
        iiter = IW'(it);
        for (int i = 0; i < n; i++) begin
            isop = (i == 0); ieop = (i == n - 1); ival = 1'b1;
            exp_w.push_back(i);
            tick();
        end
        isop = 1'b0; ieop = 1'b0; ival = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int start = done_cnt;
        int t = 0;
        while (done_cnt == start && t < budget) begin
            if (toggle) idec_rdy = ~idec_rdy;
            tick();
            t++;
        end
        idec_rdy = 1'b1;
        chk_cnt++;
        if (done_cnt == start) $display("FAIL done_timeout waited=%0d", t);
        else pass_cnt++;
        chk_cnt++;
        if (exp_w.size() + exp_r.size() + exp_v.size() != 0)
            $display("FAIL queues_left w=%0d r=%0d v=%0d", exp_w.size(), exp_r.size(), exp_v.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        ireset = 1'b0;
        tick(); tick();
        chk_cnt++;
        if ({ordy, owrite, oread, ordval, ofirst, olast, obusy, odone, oerr} !== 9'b0)
            $display("FAIL reset_flags got=%b exp=0", {ordy, owrite, oread, ordval, ofirst, olast, obusy, odone, oerr});
        else pass_cnt++;
        chk_cnt++;
        if ({owaddr, oraddr0, oraddr1, oiter} !== '0)
            $display("FAIL reset_buses got=%0h exp=0", {owaddr, oraddr0, oraddr1, oiter});
        else pass_cnt++;
        ireset = 1'b1;
        tick();
        chk_cnt++;
        if (ordy !== 1'b1) $display("FAIL reset_ordy got=%b exp=1", ordy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        send_frame(8, 1);
        chk_cnt++;
        if (obusy !== 1'b1 || ordy !== 1'b0) $display("FAIL basic_busy got=%b%b exp=10", obusy, ordy);
        else pass_cnt++;
        wait_done(200, 1'b0);
        chk_cnt++;
        if (obusy !== 1'b0 || ordy !== 1'b1) $display("FAIL basic_idle got=%b%b exp=01", obusy, ordy);
        else pass_cnt++;
    endtask

    task automatic test_multi_iter();
        send_frame(6, 3);
        wait_done(300, 1'b0);
    endtask

    task automatic test_rdy_toggle();
        send_frame(4, 0);
        wait_done(300, 1'b1);
    endtask

    task automatic test_clkena();
        push_reads(3, 1);
        iiter = IW'(1);
        isop = 1'b1; ival = 1'b1; exp_w.push_back(0);
        tick();
        isop = 1'b0; iclkena = 1'b0;
        tick(); tick();
        iclkena = 1'b1; exp_w.push_back(1);
        tick();
        ieop = 1'b1; exp_w.push_back(2);
        tick();
        ieop = 1'b0; ival = 1'b0;
        wait_done(200, 1'b0);
    endtask

    task automatic test_overflow();
        push_reads(NMAX, 1);
        iiter = IW'(1);
        for (int i = 0; i < NMAX + 3; i++) begin
            isop = (i == 0); ieop = 1'b0; ival = 1'b1;
            if (i < NMAX) exp_w.push_back(i);
            else begin
                chk_cnt++;
                if (ordy !== 1'b0) $display("FAIL overflow_ordy sample=%0d got=%b exp=0", i, ordy);
                else pass_cnt++;
            end
            tick();
        end
        isop = 1'b0; ival = 1'b0;
        wait_done(2000, 1'b0);
    endtask

    task automatic test_odd();
        send_frame(5, 2);
        chk_cnt++;
        if (oerr !== EXP_ERR) $display("FAIL odd_err_entry got=%b exp=%b", oerr, EXP_ERR);
        else pass_cnt++;
        wait_done(300, 1'b0);
        chk_cnt++;
        if (oerr !== EXP_ERR) $display("FAIL odd_err_hold got=%b exp=%b", oerr, EXP_ERR);
        else pass_cnt++;
        send_frame(2, 1);
        chk_cnt++;
        if (oerr !== 1'b0) $display("FAIL odd_err_clear got=%b exp=0", oerr);
        else pass_cnt++;
        wait_done(200, 1'b0);
    endtask

    task automatic test_reset_mid_decode();
        int dc;
        send_frame(8, 4);
        repeat (5) tick();
        chk_cnt++;
        if (obusy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", obusy);
        else pass_cnt++;
        ireset = 1'b0;
        tick();
        chk_cnt++;
        if ({ordy, owrite, oread, ordval, ofirst, olast, obusy, odone, oerr} !== 9'b0)
            $display("FAIL mid_reset_flags got=%b exp=0", {ordy, owrite, oread, ordval, ofirst, olast, obusy, odone, oerr});
        else pass_cnt++;
        exp_w.delete(); exp_r.delete(); exp_v.delete(); rd_tick.delete();
        dc = done_cnt;
        ireset = 1'b1;
        tick();
        chk_cnt++;
        if (ordy !== 1'b1) $display("FAIL mid_ordy got=%b exp=1", ordy);
        else pass_cnt++;
        repeat (6) tick();
        chk_cnt++;
        if (done_cnt !== dc) $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, dc);
        else pass_cnt++;
        send_frame(2, 1);
        wait_done(200, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_iter();
        test_rdy_toggle();
        test_clkena();
        test_overflow();
        test_odd();
        test_reset_mid_decode();
        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
